serv_fetch: RTL and testbench
=============================

SERV_FETCH -- requirements
Module: serv_fetch

Interface
REQ-001 SHALL have parameter PREFETCH, default 1, meaning: 1 enables the one-word prefetch of PC+4; 0 disables it.
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port i_rst, input, 1: reset is asynchronous and active-high.
REQ-004 SHALL have port i_req, input, 1: one-cycle request to fetch the instruction at i_pc.
REQ-005 SHALL have port i_pc, input, 32: fetch address, sampled when i_req=1.
REQ-006 SHALL have port i_flush, input, 1: invalidates the prefetch buffer.
REQ-007 SHALL have port o_ibus_adr, output, 32: Wishbone instruction address, bits [1:0] always 0.
REQ-008 SHALL have port o_ibus_cyc, output, 1: Wishbone cycle/strobe.
REQ-009 SHALL have port i_ibus_rdt, input, 32: Wishbone read data.
REQ-010 SHALL have port i_ibus_ack, input, 1: Wishbone acknowledge.
REQ-011 SHALL have port o_wb_rdt, output, 32: instruction word delivered to the decoder.
REQ-012 SHALL have port o_wb_en, output, 1: one-cycle strobe marking o_wb_rdt valid.
REQ-013 SHALL have port o_busy, output, 1: high when state is not IDLE.

Function
REQ-014 SHALL implement states IDLE, FETCH and PREFETCH; PREFETCH is unreachable when PREFETCH=0.
REQ-015 SHALL keep buffer registers buf_adr[31:0], buf_rdt[31:0], buf_valid, plus pend_valid and pend_pc[31:0].
REQ-016 IDLE, i_req, buf_valid, buf_adr=={i_pc[31:2],2'b00}, no i_flush: hit; SHALL set o_wb_rdt=buf_rdt and pulse o_wb_en next cycle, with no bus access.
REQ-017 On a hit with PREFETCH=1, SHALL clear buf_valid and enter PREFETCH with o_ibus_adr=buf_adr+4 in the same edge.
REQ-018 IDLE, i_req on a miss (or with i_flush): SHALL enter FETCH with o_ibus_adr={i_pc[31:2],2'b00}.
REQ-019 o_ibus_cyc SHALL be 1 exactly while in FETCH or PREFETCH; a cycle is never aborted before i_ibus_ack.
REQ-020 FETCH on i_ibus_ack: SHALL register i_ibus_rdt into o_wb_rdt and pulse o_wb_en the next cycle, giving 1-cycle latency from ack.
REQ-021 After the FETCH ack: PREFETCH=1 goes to PREFETCH with adr+4; PREFETCH=0 goes to IDLE.
REQ-022 PREFETCH on ack, no pending request: SHALL set buf_rdt=i_ibus_rdt, buf_adr=o_ibus_adr, buf_valid=1 (unless i_flush is high that cycle or was seen since the prefetch started), then go IDLE.
REQ-023 i_req during PREFETCH: SHALL set pend_valid=1 and pend_pc=i_pc.
REQ-024 On the PREFETCH ack, pending address equal and no flush: SHALL deliver i_ibus_rdt as a FETCH ack does (REQ-020) and start the next prefetch at adr+4.
REQ-025 On the PREFETCH ack, pending address different or flushed: SHALL discard the data and enter FETCH at pend_pc.
REQ-026 An i_req coinciding with the PREFETCH ack SHALL be treated as pending for that ack.
REQ-027 i_req while in FETCH is a protocol violation and SHALL be ignored.
REQ-028 i_flush SHALL clear buf_valid in any state.
REQ-029 Address arithmetic SHALL be 32-bit modulo: 0xFFFFFFFC+4 -> 0x00000000.
REQ-030 o_wb_rdt SHALL hold its value between o_wb_en pulses.
REQ-031 o_wb_en SHALL never be high on two consecutive cycles.

Reset
REQ-032 Asserting i_rst SHALL immediately, without waiting for clk, force: state=IDLE, o_ibus_cyc=0, o_ibus_adr=0, o_wb_en=0, o_wb_rdt=0, buf_valid=0, pend_valid=0.
REQ-033 Reset mid-cycle SHALL drop the outstanding bus transaction; an ack arriving after reset is released is ignored.
REQ-034 First i_req after reset SHALL always miss.

Verification
REQ-035 Miss then prefetch: i_req with i_pc=0x100, ack with 0x00500093 after 2 wait cycles -> o_wb_en one cycle after ack, o_wb_rdt=0x00500093; o_ibus_cyc re-asserts with adr=0x104.
REQ-036 Hit: after REQ-035 the prefetch of 0x104 completes, then i_req with i_pc=0x104 -> o_wb_en next cycle with no ibus cycle, then a prefetch at 0x108.
REQ-037 Branch miss: buffer holds 0x104, i_req with i_pc=0x200 -> FETCH at 0x200, buffer unused.
REQ-038 Request during prefetch: i_req with i_pc=0x108 while prefetch of 0x108 is pending -> delivered on its ack. Repeat with i_pc=0x300 -> data dropped, FETCH at 0x300.
REQ-039 Flush and wrap: i_flush during the prefetch of 0x104, then i_req with i_pc=0x104 -> miss. Also i_pc=0xFFFFFFFC -> prefetch address 0x00000000.
REQ-040 Reset mid-FETCH: i_rst high while o_ibus_cyc=1 -> o_ibus_cyc=0 with no clock edge; a later ack produces no o_wb_en.

Source files
------------

// File: rtl/serv_fetch.sv
// serv_fetch: instruction fetch unit with an optional one-word prefetch buffer.
// A demand fetch (FETCH) is issued on a buffer miss; after every delivered word
// the unit speculatively reads the next sequential word (PREFETCH) into a
// one-entry buffer so that a straight-line request can be answered without
// touching the bus.
module serv_fetch #(
  parameter int PREFETCH = 1
) (
  input  logic        clk,
  input  logic        i_rst,
  input  logic        i_req,
  input  logic [31:0] i_pc,
  input  logic        i_flush,
  output logic [31:0] o_ibus_adr,
  output logic        o_ibus_cyc,
  input  logic [31:0] i_ibus_rdt,
  input  logic        i_ibus_ack,
  output logic [31:0] o_wb_rdt,
  output logic        o_wb_en,
  output logic        o_busy
);

  localparam bit LP_PF = (PREFETCH != 0);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_FETCH    = 2'd1,
    S_PREFETCH = 2'd2
  } state_t;

  state_t      r_state;
  logic [31:0] r_adr;
  logic [31:0] r_wb_rdt;
  logic        r_wb_en;
  logic [31:0] r_buf_adr;
  logic [31:0] r_buf_rdt;
  logic        r_buf_valid;
  logic        r_pend_valid;
  logic [31:0] r_pend_adr;
  // A flush was observed at some point during the current prefetch.
  logic        r_flushed;

  logic [31:0] w_pc_adr;
  logic [31:0] w_adr_inc;
  logic        w_hit;
  logic        w_pend_any;
  logic [31:0] w_pend_adr;
  logic        w_flush_any;
  logic        w_unused;

  // Word-aligned request address; the byte offset bits never reach the bus.
  assign w_pc_adr    = {i_pc[31:2], 2'b00};
  assign w_unused    = ^i_pc[1:0];
  assign w_adr_inc   = r_adr + 32'd4;
  assign w_hit       = r_buf_valid && (r_buf_adr == w_pc_adr) && !i_flush;
  // A request landing on the same cycle as the prefetch ack counts as pending.
  assign w_pend_any  = r_pend_valid | i_req;
  assign w_pend_adr  = i_req ? w_pc_adr : r_pend_adr;
  assign w_flush_any = r_flushed | i_flush;

  assign o_ibus_adr  = r_adr;
  assign o_ibus_cyc  = (r_state != S_IDLE);
  assign o_busy      = (r_state != S_IDLE);
  assign o_wb_rdt    = r_wb_rdt;
  assign o_wb_en     = r_wb_en;

  // Fetch controller: state, bus address, delivery strobe, buffer and pending request.
  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      r_state      <= S_IDLE;
      r_adr        <= '0;
      r_wb_rdt     <= '0;
      r_wb_en      <= 1'b0;
      r_buf_adr    <= '0;
      r_buf_rdt    <= '0;
      r_buf_valid  <= 1'b0;
      r_pend_valid <= 1'b0;
      r_pend_adr   <= '0;
      r_flushed    <= 1'b0;
    end else begin
      r_wb_en <= 1'b0;
      if (i_flush) r_buf_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_req) begin
            if (w_hit) begin
              r_wb_rdt <= r_buf_rdt;
              r_wb_en  <= 1'b1;
              if (LP_PF) begin
                r_buf_valid <= 1'b0;
                r_state     <= S_PREFETCH;
                r_adr       <= r_buf_adr + 32'd4;
                r_flushed   <= 1'b0;
              end
            end else begin
              r_state <= S_FETCH;
              r_adr   <= w_pc_adr;
            end
          end
        end
        S_FETCH: begin
          // New requests here are a protocol violation and are not looked at.
          if (i_ibus_ack) begin
            r_wb_rdt <= i_ibus_rdt;
            r_wb_en  <= 1'b1;
            if (LP_PF) begin
              r_state   <= S_PREFETCH;
              r_adr     <= w_adr_inc;
              r_flushed <= 1'b0;
            end else begin
              r_state <= S_IDLE;
            end
          end
        end
        S_PREFETCH: begin
          r_flushed <= w_flush_any;
          if (i_req) begin
            r_pend_valid <= 1'b1;
            r_pend_adr   <= w_pc_adr;
          end
          if (i_ibus_ack) begin
            r_pend_valid <= 1'b0;
            if (!w_pend_any) begin
              if (!w_flush_any) begin
                r_buf_rdt   <= i_ibus_rdt;
                r_buf_adr   <= r_adr;
                r_buf_valid <= 1'b1;
              end
              r_state <= S_IDLE;
            end else if ((w_pend_adr == r_adr) && !w_flush_any) begin
              // Speculation paid off: hand the word over and keep streaming.
              r_wb_rdt  <= i_ibus_rdt;
              r_wb_en   <= 1'b1;
              r_adr     <= w_adr_inc;
              r_flushed <= 1'b0;
            end else begin
              r_state <= S_FETCH;
              r_adr   <= w_pend_adr;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serv_fetch.sv
// Bench for serv_fetch: directed scenarios with literal expectations, then
// randomized traffic against a transaction-level model of the fetch unit.
module tb_serv_fetch;
  logic        clk = 1'b0;
  logic        rst, req, flush, ack;
  logic [31:0] pc, rdt;
  logic [31:0] o_ibus_adr, o_wb_rdt;
  logic        o_ibus_cyc, o_wb_en, o_busy;

  int n_pass = 0;
  int n_total = 0;
  bit sem = 1'b0;
  logic prev_en = 1'b0;

  serv_fetch #(.PREFETCH(1)) dut (
    .clk(clk), .i_rst(rst), .i_req(req), .i_pc(pc), .i_flush(flush),
    .o_ibus_adr(o_ibus_adr), .o_ibus_cyc(o_ibus_cyc),
    .i_ibus_rdt(rdt), .i_ibus_ack(ack),
    .o_wb_rdt(o_wb_rdt), .o_wb_en(o_wb_en), .o_busy(o_busy)
  );

  always #5 clk = ~clk;

  // Model: at most one outstanding bus read (0 none, 1 demand, 2 speculative),
  // a one-word buffer, an optional waiting request, and the word handed over.
  int          m_kind;
  logic [31:0] m_adr, m_dat, m_buf_adr, m_buf_dat, m_pend_pc, m_last;
  bit          m_en, m_buf_ok, m_pend_ok, m_dirty;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A1234;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic deliver(input logic [31:0] d);
    m_en  = 1'b1;
    m_dat = d;
  endtask

  task automatic start_spec(input logic [31:0] a);
    m_kind  = 2;
    m_adr   = a;
    m_dirty = 1'b0;
  endtask

  task automatic m_edge();
    logic [31:0] pa;
    pa   = {pc[31:2], 2'b00};
    m_en = 1'b0;
    if (rst) begin
      m_kind = 0; m_adr = 0; m_dat = 0; m_buf_ok = 0; m_pend_ok = 0; m_dirty = 0;
      return;
    end
    if (flush) m_buf_ok = 1'b0;
    if (m_kind == 0) begin
      if (req) begin
        m_last = pa;
        if (m_buf_ok && m_buf_adr == pa && !flush) begin
          deliver(m_buf_dat);
          m_buf_ok = 1'b0;
          start_spec(pa + 32'd4);
        end else begin
          m_kind = 1;
          m_adr  = pa;
        end
      end
    end else if (m_kind == 1) begin
      if (ack) begin
        deliver(rdt);
        start_spec(m_adr + 32'd4);
      end
    end else begin
      if (flush) m_dirty = 1'b1;
      if (req) begin
        m_pend_ok = 1'b1;
        m_pend_pc = pa;
        m_last    = pa;
      end
      if (ack) begin
        if (!m_pend_ok) begin
          if (!m_dirty) begin
            m_buf_ok = 1'b1; m_buf_adr = m_adr; m_buf_dat = rdt;
          end
          m_kind = 0;
        end else if (m_pend_pc == m_adr && !m_dirty) begin
          deliver(rdt);
          start_spec(m_adr + 32'd4);
        end else begin
          m_kind = 1;
          m_adr  = m_pend_pc;
        end
        m_pend_ok = 1'b0;
      end
    end
  endtask

  // One clock: DUT and model both take the edge, outputs are compared mid-cycle.
  task automatic tick();
    @(posedge clk);
    m_edge();
    @(negedge clk);
    chk("cyc", {31'd0, o_ibus_cyc}, {31'd0, m_kind != 0});
    chk("busy", {31'd0, o_busy}, {31'd0, m_kind != 0});
    chk("wb_en", {31'd0, o_wb_en}, {31'd0, m_en});
    chk("wb_rdt", o_wb_rdt, m_dat);
    if (m_kind != 0) chk("ibus_adr", o_ibus_adr, m_adr);
    if (o_wb_en && prev_en) chk("wb_en_back_to_back", 32'd1, 32'd0);
    if (o_wb_en) begin
      $display("deliver pc=%h rdt=%h", m_last, o_wb_rdt);
      if (sem) chk("data_vs_memory", o_wb_rdt, memf(m_last));
    end
    prev_en = o_wb_en;
  endtask

  task automatic step(input logic r, input logic [31:0] p, input logic f,
                      input logic a, input logic [31:0] d);
    req = r; pc = p; flush = f; ack = a; rdt = d;
    tick();
    req = 0; flush = 0; ack = 0; rdt = 0;
  endtask

  task automatic lit(input logic c, input logic [31:0] ad, input logic e, input logic [31:0] rd);
    chk("lit_cyc", {31'd0, o_ibus_cyc}, {31'd0, c});
    if (c) chk("lit_adr", o_ibus_adr, ad);
    chk("lit_en", {31'd0, o_wb_en}, {31'd0, e});
    if (e) chk("lit_rdt", o_wb_rdt, rd);
  endtask

  initial begin
    rst = 1; req = 0; pc = 0; flush = 0; ack = 0; rdt = 0; m_last = 0;
    m_buf_adr = 0; m_buf_dat = 0; m_pend_pc = 0;
    m_edge();
    @(negedge clk);
    chk("rst_cyc", {31'd0, o_ibus_cyc}, 32'd0);
    chk("rst_adr", o_ibus_adr, 32'd0);
    chk("rst_en", {31'd0, o_wb_en}, 32'd0);
    chk("rst_rdt", o_wb_rdt, 32'd0);
    chk("rst_busy", {31'd0, o_busy}, 32'd0);
    rst = 0;

    // Miss then prefetch, with two wait cycles before the ack.
    step(1, 32'h100, 0, 0, 0);          lit(1, 32'h100, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);                lit(1, 32'h100, 0, 0);
    step(0, 0, 0, 1, 32'h00500093);     lit(1, 32'h104, 1, 32'h00500093);
    // Prefetch of 0x104 lands in the buffer, then a hit on it.
    step(0, 0, 0, 1, 32'h00000013);     lit(0, 0, 0, 0);
    step(1, 32'h104, 0, 0, 0);          lit(1, 32'h108, 1, 32'h00000013);
    // Request matching the outstanding prefetch is served by its ack.
    step(1, 32'h108, 0, 0, 0);          lit(1, 32'h108, 0, 0);
    step(0, 0, 0, 1, 32'h11);           lit(1, 32'h10C, 1, 32'h11);
    // Request not matching: data dropped, demand fetch at 0x300.
    step(1, 32'h300, 0, 0, 0);
    step(0, 0, 0, 1, 32'h22);           lit(1, 32'h300, 0, 0);
    chk("hold_rdt", o_wb_rdt, 32'h11);
    step(0, 0, 0, 1, 32'h33);           lit(1, 32'h304, 1, 32'h33);
    step(0, 0, 0, 1, 32'h44);           lit(0, 0, 0, 0);
    // Branch away from the buffered word.
    step(1, 32'h200, 0, 0, 0);          lit(1, 32'h200, 0, 0);
    step(0, 0, 0, 1, 32'h55);           lit(1, 32'h204, 1, 32'h55);
    // Flush during the prefetch: the next sequential request must miss.
    step(0, 0, 1, 0, 0);
    step(0, 0, 0, 1, 32'h66);           lit(0, 0, 0, 0);
    step(1, 32'h204, 0, 0, 0);          lit(1, 32'h204, 0, 0);
    step(0, 0, 0, 1, 32'h77);           lit(1, 32'h208, 1, 32'h77);
    step(0, 0, 0, 1, 32'h88);
    // Address wrap.
    step(1, 32'hFFFFFFFC, 0, 0, 0);     lit(1, 32'hFFFFFFFC, 0, 0);
    step(0, 0, 0, 1, 32'h99);           lit(1, 32'h00000000, 1, 32'h99);
    step(0, 0, 0, 1, 32'hAA);           lit(0, 0, 0, 0);
    // Reset in the middle of a demand fetch acts without a clock edge.
    step(1, 32'h400, 0, 0, 0);          lit(1, 32'h400, 0, 0);
    rst = 1;
    #1;
    chk("async_cyc", {31'd0, o_ibus_cyc}, 32'd0);
    chk("async_adr", o_ibus_adr, 32'd0);
    chk("async_busy", {31'd0, o_busy}, 32'd0);
    @(negedge clk);
    step(0, 0, 0, 0, 0);
    rst = 0;
    step(0, 0, 0, 1, 32'hDEAD);         lit(0, 0, 0, 0);
    // Buffer held address 0 before reset; the first request must still miss.
    step(1, 32'h0, 0, 0, 0);            lit(1, 32'h0, 0, 0);
    step(0, 0, 0, 1, 32'h1);            lit(1, 32'h4, 1, 32'h1);

    // Randomized traffic with a memory image, starting from reset.
    rst = 1;
    step(0, 0, 0, 0, 0);
    rst = 0;
    sem = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      int sel;
      rst = ($urandom_range(0, 249) == 0);
      if (rst) begin
        #1;
        chk("async_cyc_rand", {31'd0, o_ibus_cyc}, 32'd0);
        chk("async_en_rand", {31'd0, o_wb_en}, 32'd0);
      end
      req = !rst && !o_wb_en && ($urandom_range(0, 2) == 0);
      sel = $urandom_range(0, 9);
      if (sel < 6)       pc = m_last + 32'd4;
      else if (sel < 8)  pc = m_last;
      else if (sel == 8) pc = {24'd0, $urandom_range(0, 63), 2'b00};
      else               pc = 32'hFFFFFFFC;
      pc = pc | {30'd0, $urandom_range(0, 3)};
      flush = ($urandom_range(0, 9) == 0);
      ack = o_ibus_cyc && ($urandom_range(0, 2) == 0);
      rdt = ack ? memf(o_ibus_adr) : $urandom;
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
